// File: rtl/echo_request_input.sv
// Receive side of the echo request path: buffers 96-bit indications, drops non-SAY tags, replays say(meth, v).
// Optional build macro ECHO_REQUEST_INPUT_BAD_TAG_COUNT_EN adds a saturating bad_tag_count output.
module echo_request_input #(
    parameter int unsigned DEPTH   = 4,
    parameter logic [31:0] SAY_TAG = 32'd1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enq__ENA,
    input  logic [95:0] enq_v,
    output logic        enq__RDY,
    output logic        say__ENA,
    output logic [31:0] say_meth,
    output logic [31:0] say_v,
    input  logic        say__RDY
`ifdef ECHO_REQUEST_INPUT_BAD_TAG_COUNT_EN
    ,
    output logic [15:0] bad_tag_count
`endif
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic w_not_full;
    logic w_not_empty;
    logic w_tag_ok;
    logic w_accept;
    logic w_wr;
    logic w_rd;

    assign w_not_full  = (r_count != FULL_CNT);
    assign w_not_empty = (r_count != '0);
    assign w_tag_ok    = (enq_v[95:64] == SAY_TAG);
    assign w_accept    = enq__ENA && w_not_full;
    assign w_wr        = w_accept && w_tag_ok;
    assign w_rd        = w_not_empty && say__RDY;

    assign enq__RDY = w_not_full;
    assign say__ENA = w_rd;

    // Head data is gated to zero when empty so the consumer never sees stale entries.
    always_comb begin
        say_meth = '0;
        say_v    = '0;
        if (w_not_empty) begin
            say_meth = r_mem[r_rptr][63:32];
            say_v    = r_mem[r_rptr][31:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && w_wr) begin
            r_mem[r_wptr] <= enq_v[63:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ECHO_REQUEST_INPUT_BAD_TAG_COUNT_EN
    logic [15:0] r_bad_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bad_cnt <= '0;
        end else if (w_accept && !w_tag_ok && (r_bad_cnt != '1)) begin
            r_bad_cnt <= r_bad_cnt + 16'd1;
        end
    end

    assign bad_tag_count = r_bad_cnt;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            a_count_range: assert (r_count <= FULL_CNT)
                else $error("count exceeds DEPTH");
            a_no_write_full: assert (!(w_wr && (r_count == FULL_CNT)))
                else $error("write while full");
            a_no_read_empty: assert (!(w_rd && (r_count == '0)))
                else $error("read while empty");
        end
    end

endmodule

// File: tb/tb_echo_request_input.sv
// Scoreboard bench for echo_request_input: expected {meth, v} queued on accept, popped on say__ENA.
module tb_echo_request_input;

    localparam int unsigned DEPTH   = 4;
    localparam logic [31:0] SAY_TAG = 32'd1;

    logic        CLK = 1'b0;
    logic        RST;
    logic        enq__ENA;
    logic [95:0] enq_v;
    logic        enq__RDY;
    logic        say__ENA;
    logic [31:0] say_meth;
    logic [31:0] say_v;
    logic        say__RDY;
`ifdef ECHO_REQUEST_INPUT_BAD_TAG_COUNT_EN
    logic [15:0] bad_tag_count;
    int unsigned m_bad = 0;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [63:0] sb [$];

    echo_request_input #(.DEPTH(DEPTH), .SAY_TAG(SAY_TAG)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .enq__ENA (enq__ENA),
        .enq_v    (enq_v),
        .enq__RDY (enq__RDY),
        .say__ENA (say__ENA),
        .say_meth (say_meth),
        .say_v    (say_v),
        .say__RDY (say__RDY)
`ifdef ECHO_REQUEST_INPUT_BAD_TAG_COUNT_EN
        ,
        .bad_tag_count (bad_tag_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check outputs, then advance the model for the coming posedge.
    task automatic step(input logic en, input logic [31:0] tg, input logic [31:0] meth,
                        input logic [31:0] v, input logic rdy, input logic rst);
        logic exp_rdy;
        logic exp_ena;
        @(negedge CLK);
        RST      = rst;
        enq__ENA = en;
        enq_v    = {tg, meth, v};
        say__RDY = rdy;
        #1;
        exp_rdy = (sb.size() != DEPTH);
        exp_ena = (sb.size() != 0) && rdy;
        check("enq_rdy", {63'd0, enq__RDY}, {63'd0, exp_rdy});
        check("say_ena", {63'd0, say__ENA}, {63'd0, exp_ena});
        if (sb.size() != 0) begin
            check("say_data", {say_meth, say_v}, sb[0]);
        end else begin
            check("say_zero", {say_meth, say_v}, 64'd0);
        end
`ifdef ECHO_REQUEST_INPUT_BAD_TAG_COUNT_EN
        check("bad_cnt", {48'd0, bad_tag_count}, 64'(m_bad));
`endif
        if (rst) begin
            sb.delete();
`ifdef ECHO_REQUEST_INPUT_BAD_TAG_COUNT_EN
            m_bad = 0;
`endif
        end else begin
            if (exp_ena) void'(sb.pop_front());
            if (en && exp_rdy) begin
                if (tg == SAY_TAG) sb.push_back({meth, v});
`ifdef ECHO_REQUEST_INPUT_BAD_TAG_COUNT_EN
                else if (m_bad != 16'hFFFF) m_bad++;
`endif
            end
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'd0, 32'd0, 32'd0, rdy, 1'b0);
    endtask

    initial begin
        RST = 1'b1; enq__ENA = 1'b0; enq_v = '0; say__RDY = 1'b0;
        repeat (2) @(posedge CLK);

        // Reset state
        idle(1'b1);
        check("reset_rdy", {63'd0, enq__RDY}, 64'd1);
        check("reset_ena", {63'd0, say__ENA}, 64'd0);
        check("reset_data", {say_meth, say_v}, 64'd0);

        // Single message, one-cycle latency
        step(1'b1, SAY_TAG, 32'h5, 32'hDEADBEEF, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Fill to full, ignored 5th enqueue, ordered drain
        for (int i = 1; i <= 4; i++) step(1'b1, SAY_TAG, 32'h10, 32'(i), 1'b0, 1'b0);
        step(1'b1, SAY_TAG, 32'h10, 32'd5, 1'b0, 1'b0);
        step(1'b1, SAY_TAG, 32'h10, 32'd6, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Simultaneous enqueue/dequeue at count 2, pointers wrap
        step(1'b1, SAY_TAG, 32'h20, 32'h100, 1'b0, 1'b0);
        step(1'b1, SAY_TAG, 32'h20, 32'h101, 1'b0, 1'b0);
        for (int i = 2; i < 12; i++) step(1'b1, SAY_TAG, 32'h20, 32'h100 + 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Bad tag between valid messages
        step(1'b1, SAY_TAG, 32'h30, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'd7, 32'h30, 32'hBAD, 1'b0, 1'b0);
        step(1'b1, SAY_TAG, 32'h30, 32'hB, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Bad tag offered while full is rejected and not counted
        for (int i = 0; i < 4; i++) step(1'b1, SAY_TAG, 32'h40, 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'd9, 32'h40, 32'h99, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Reset mid-operation with a concurrent enqueue
        for (int i = 0; i < 3; i++) step(1'b1, SAY_TAG, 32'h50, 32'(i), 1'b0, 1'b0);
        step(1'b1, SAY_TAG, 32'h50, 32'h77, 1'b1, 1'b1);
        idle(1'b1);
        check("post_rst_ena", {63'd0, say__ENA}, 64'd0);
        check("post_rst_rdy", {63'd0, enq__RDY}, 64'd1);
        idle(1'b1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 32'd3 : SAY_TAG,
                 $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end
        for (int i = 0; i < 6; i++) idle(1'b1);
        check("drained", 64'(sb.size()), 64'd0);

`ifdef ECHO_REQUEST_INPUT_BAD_TAG_COUNT_EN
        // Saturation of the bad-tag counter
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < 65540; i++) step(1'b1, 32'd2, 32'd0, 32'd0, 1'b1, 1'b0);
        idle(1'b1);
        check("bad_sat", {48'd0, bad_tag_count}, 64'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
